fp128_cmp_cond_pipe: RTL and testbench
======================================

Name: fp128_cmp_cond_pipe

Overview:
- Pipelined condition-select and exception stage sitting directly downstream of the 128-bit FP compare unit.
- Accepts the 16-bit compare vector and snan flag with an op tag, condition code and signaling-compare bit.
- Produces a registered 1-bit predicate result plus a per-op invalid flag over a valid/ready handshake.
- Maintains sticky invalid/illegal-condition flags for the FP status register.

Parameters:
TAGW, 6, width of the op tag carried alongside each compare
LAT2, 1, 1 = two-stage pipeline (S1 input reg + S2 output reg); 0 = single output register (S2 only)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  request present
in_ready  output  1  stage can accept request this cycle
in_cmp  input  16  compare vector from compare unit (bit0 eq, 1 lt, 2 le, 3 lt-magnitude, 4 unordered, 8 ne, 9 ge, 10 gt, 11 ge-magnitude, 12 ordered)
in_snan  input  1  signaling NaN detected on either operand
in_cond  input  4  index of in_cmp bit to select
in_sig  input  1  signaling compare: any unordered raises invalid
in_tag  input  TAGW  op tag
out_valid  output  1  result present
out_ready  input  1  consumer accepts result
out_res  output  1  selected predicate
out_inv  output  1  this op raised invalid
out_ill  output  1  this op used a reserved condition code
out_tag  output  TAGW  tag of result
clr_flags  input  1  clear sticky flags
flag_inv  output  1  sticky invalid
flag_ill  output  1  sticky illegal-condition

Behaviour:
- Reset: all valid bits 0; out_res, out_inv, out_ill, out_tag, flag_inv, flag_ill all 0; in_ready 1 after reset deasserts. Reset mid-operation discards all in-flight ops with no output.
- Compute:
  - res = in_cmp[in_cond].
  - Reserved conds 5,6,7,13,14,15 force res=0 and ill=1.
  - inv = in_snan | (in_sig & in_cmp[4]).
  - All computed in S1 (LAT2=1) or at S2 capture (LAT2=0).
- Handshake:
  - Transfer in occurs on in_valid & in_ready; transfer out on out_valid & out_ready.
  - adv2 = !out_valid | out_ready.
  - LAT2=1:
    - in_ready = !s1_valid | adv2 (combinational on out_ready).
    - S1 moves to S2 when adv2.
    - S2 valid clears when out taken and S1 empty.
  - LAT2=0: in_ready = adv2.
  - Output fields stay stable while out_valid & !out_ready.
  - in_* are ignored when in_valid=0.
- Latency (LAT2=1): request accepted at edge k -> out_valid at edge k+2 with no stall. Throughput 1/cycle with out_ready held 1. LAT2=0: latency 1.
- Stall:
  - Full: s1_valid & out_valid & !out_ready -> in_ready=0, no state change.
  - Simultaneous in accept and out take with both stages full: S1 shifts to S2 and new op enters S1 in the same edge.
- Sticky flags:
  - Set on the edge an op enters S2 with inv/ill = 1, not at output transfer.
  - clr_flags clears both.
  - clr_flags and a set in the same cycle: set wins (flag=1).
- No combinational path from in_* data to out_* data.

Test Plan:
- Reset then single op: in_cmp=16'h1E07 (eq,lt,le), cond=0, sig=0, snan=0, tag=5 -> out_valid 2 cycles later, res=1, inv=0, ill=0, tag=5; flags stay 0.
- Unordered signaling: in_cmp=16'h1010, cond=1, sig=1 -> res=0, inv=1, flag_inv=1. Same with sig=0, snan=0 -> inv=0. Same with snan=1 -> inv=1.
- Reserved cond=6 with in_cmp=16'hFFFF -> res=0, ill=1, flag_ill=1. Then clr_flags pulsed alone -> flag_ill=0 next edge. Then clr_flags in the same cycle an ill op enters S2 -> flag_ill=1.
- Back-pressure: stream tags 1..6 with out_ready=0 for 4 cycles -> exactly 2 accepted, in_ready=0, out_tag held 1. Release out_ready=1 -> tags 1..6 emerge in order, one per cycle, none lost or duplicated.
- Full throughput: 32 back-to-back ops with random cond/cmp, out_ready=1 -> 32 results, 1/cycle, each matching the compute rules against a scoreboard.
- Reset asserted asynchronously mid-stream with 2 ops in flight -> out_valid drops immediately, flags 0, no stale result after rst release.

Source files
------------

// File: rtl/fp128_cmp_cond_pipe.sv
// Condition-select and exception stage behind the 128-bit FP compare unit.
// Picks one predicate bit, flags invalid/illegal-cond, and keeps sticky status flags.
module fp128_cmp_cond_pipe #(
    parameter int unsigned TAGW = 6,
    parameter bit          LAT2 = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [15:0]     in_cmp,
    input  logic            in_snan,
    input  logic [3:0]      in_cond,
    input  logic            in_sig,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_res,
    output logic            out_inv,
    output logic            out_ill,
    output logic [TAGW-1:0] out_tag,
    input  logic            clr_flags,
    output logic            flag_inv,
    output logic            flag_ill
);

    function automatic logic is_reserved(input logic [3:0] cond);
        logic r;
        case (cond)
            4'd5, 4'd6, 4'd7, 4'd13, 4'd14, 4'd15: r = 1'b1;
            default:                               r = 1'b0;
        endcase
        return r;
    endfunction

    logic            c_res;
    logic            c_inv;
    logic            c_ill;

    always_comb begin
        c_ill = is_reserved(in_cond);
        c_res = c_ill ? 1'b0 : in_cmp[in_cond];
        // bit 4 of the compare vector is the unordered indication
        c_inv = in_snan | (in_sig & in_cmp[4]);
    end

    logic            adv2;
    logic            src_valid;
    logic            src_res;
    logic            src_inv;
    logic            src_ill;
    logic [TAGW-1:0] src_tag;

    assign adv2 = !out_valid || out_ready;

    generate
        if (LAT2) begin : g_s1
            logic            s1_valid;
            logic            s1_res;
            logic            s1_inv;
            logic            s1_ill;
            logic [TAGW-1:0] s1_tag;
            logic            accept;

            assign in_ready = !s1_valid || adv2;
            assign accept   = in_valid && in_ready;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s1_valid <= 1'b0;
                    s1_res   <= 1'b0;
                    s1_inv   <= 1'b0;
                    s1_ill   <= 1'b0;
                    s1_tag   <= '0;
                end else begin
                    if (accept) begin
                        s1_valid <= 1'b1;
                        s1_res   <= c_res;
                        s1_inv   <= c_inv;
                        s1_ill   <= c_ill;
                        s1_tag   <= in_tag;
                    end else if (adv2) begin
                        s1_valid <= 1'b0;
                    end
                end
            end

            assign src_valid = s1_valid;
            assign src_res   = s1_res;
            assign src_inv   = s1_inv;
            assign src_ill   = s1_ill;
            assign src_tag   = s1_tag;
        end else begin : g_no_s1
            assign in_ready  = adv2;
            assign src_valid = in_valid;
            assign src_res   = c_res;
            assign src_inv   = c_inv;
            assign src_ill   = c_ill;
            assign src_tag   = in_tag;
        end
    endgenerate

    logic enter_s2;
    logic flag_inv_d;
    logic flag_ill_d;

    assign enter_s2 = adv2 && src_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_res   <= 1'b0;
            out_inv   <= 1'b0;
            out_ill   <= 1'b0;
            out_tag   <= '0;
        end else if (adv2) begin
            out_valid <= src_valid;
            // Fields only move with a real op so they stay meaningful after drain.
            if (src_valid) begin
                out_res <= src_res;
                out_inv <= src_inv;
                out_ill <= src_ill;
                out_tag <= src_tag;
            end
        end
    end

    // A set in the same cycle as a clear takes priority.
    always_comb begin
        flag_inv_d = flag_inv && !clr_flags;
        flag_ill_d = flag_ill && !clr_flags;
        if (enter_s2 && src_inv) flag_inv_d = 1'b1;
        if (enter_s2 && src_ill) flag_ill_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_inv <= 1'b0;
            flag_ill <= 1'b0;
        end else begin
            flag_inv <= flag_inv_d;
            flag_ill <= flag_ill_d;
        end
    end

endmodule

// File: tb/tb_fp128_cmp_cond_pipe.sv
// Directed and scoreboarded bench for fp128_cmp_cond_pipe with the two-stage pipeline.
module tb_fp128_cmp_cond_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_cmp;
    logic        in_snan;
    logic [3:0]  in_cond;
    logic        in_sig;
    logic [5:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic        out_res;
    logic        out_inv;
    logic        out_ill;
    logic [5:0]  out_tag;
    logic        clr_flags;
    logic        flag_inv;
    logic        flag_ill;

    int total = 0;
    int bad   = 0;

    fp128_cmp_cond_pipe #(.TAGW(6), .LAT2(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_cmp    (in_cmp),
        .in_snan   (in_snan),
        .in_cond   (in_cond),
        .in_sig    (in_sig),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_inv   (out_inv),
        .out_ill   (out_ill),
        .out_tag   (out_tag),
        .clr_flags (clr_flags),
        .flag_inv  (flag_inv),
        .flag_ill  (flag_ill)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] cmp;
        logic        snan;
        logic [3:0]  cond;
        logic        sig;
        logic [5:0]  tag;
        logic        res;
        logic        inv;
        logic        ill;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Independent reference: {res, inv, ill}
    function automatic logic [2:0] model(input logic [15:0] cmp, input logic snan,
                                         input logic [3:0] cond, input logic sig);
        logic ill;
        logic res;
        logic [15:0] c;
        c   = cmp;
        ill = (cond == 4'd5) || (cond == 4'd6) || (cond == 4'd7) ||
              (cond == 4'd13) || (cond == 4'd14) || (cond == 4'd15);
        res = ill ? 1'b0 : ((c >> cond) & 16'h1) != 16'h0;
        return {res, snan | (sig & c[4]), ill};
    endfunction

    task automatic drive(input logic [15:0] cmp, input logic snan, input logic [3:0] cond,
                         input logic sig, input logic [5:0] tag);
        in_valid = 1'b1;
        in_cmp   = cmp;
        in_snan  = snan;
        in_cond  = cond;
        in_sig   = sig;
        in_tag   = tag;
    endtask

    // Presented after edge P0, accepted at P1, visible after P2.
    task automatic run_vec(input vec_t v, input int idx);
        @(posedge clk); #1;
        drive(v.cmp, v.snan, v.cond, v.sig, v.tag);
        clr_flags = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        clr_flags = 1'b0;
        chk($sformatf("v%0d_early_valid", idx), 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk($sformatf("v%0d_valid", idx), 32'(out_valid), 32'd1);
        chk($sformatf("v%0d_res", idx), 32'(out_res), 32'(v.res));
        chk($sformatf("v%0d_inv", idx), 32'(out_inv), 32'(v.inv));
        chk($sformatf("v%0d_ill", idx), 32'(out_ill), 32'(v.ill));
        chk($sformatf("v%0d_tag", idx), 32'(out_tag), 32'(v.tag));
        chk($sformatf("v%0d_flag_inv", idx), 32'(flag_inv), 32'(v.inv));
        chk($sformatf("v%0d_flag_ill", idx), 32'(flag_ill), 32'(v.ill));
    endtask

    logic [8:0] sb [$];
    logic [8:0] exp_e;
    logic [8:0] act_e;
    logic [5:0] got_tags [$];
    logic [2:0] m;

    initial begin
        //           cmp     snan cond  sig tag   res  inv  ill
        vecs[0] = {16'h1E07, 1'b0, 4'd0,  1'b0, 6'd5,  1'b1, 1'b0, 1'b0};
        vecs[1] = {16'h1010, 1'b0, 4'd1,  1'b1, 6'd6,  1'b0, 1'b1, 1'b0};
        vecs[2] = {16'h1010, 1'b0, 4'd1,  1'b0, 6'd7,  1'b0, 1'b0, 1'b0};
        vecs[3] = {16'h1010, 1'b1, 4'd1,  1'b0, 6'd8,  1'b0, 1'b1, 1'b0};
        vecs[4] = {16'hFFFF, 1'b0, 4'd6,  1'b0, 6'd9,  1'b0, 1'b0, 1'b1};
        vecs[5] = {16'h1E07, 1'b0, 4'd10, 1'b0, 6'd10, 1'b1, 1'b0, 1'b0};
        vecs[6] = {16'h0100, 1'b0, 4'd8,  1'b0, 6'd11, 1'b1, 1'b0, 1'b0};
        vecs[7] = {16'h0100, 1'b0, 4'd4,  1'b1, 6'd12, 1'b0, 1'b0, 1'b0};
        vecs[8] = {16'hFFFF, 1'b1, 4'd15, 1'b0, 6'd13, 1'b0, 1'b1, 1'b1};
        vecs[9] = {16'h1010, 1'b0, 4'd12, 1'b1, 6'd14, 1'b1, 1'b1, 1'b0};

        rst = 1'b1; in_valid = 1'b0; in_cmp = '0; in_snan = 1'b0; in_cond = '0;
        in_sig = 1'b0; in_tag = '0; out_ready = 1'b1; clr_flags = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        chk("rst_out_res", 32'({out_res, out_inv, out_ill}), 32'd0);
        chk("rst_flags", 32'({flag_inv, flag_ill}), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // clr alone, then clr coinciding with an illegal op entering S2
        run_vec(vecs[4], 10);
        @(posedge clk); #1 clr_flags = 1'b1;
        @(posedge clk); #1 clr_flags = 1'b0;
        chk("clr_alone_flag_ill", 32'(flag_ill), 32'd0);
        drive(16'hFFFF, 1'b0, 4'd6, 1'b0, 6'd20);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        clr_flags = 1'b1;
        @(posedge clk); #1;
        clr_flags = 1'b0;
        chk("clr_vs_set_flag_ill", 32'(flag_ill), 32'd1);
        chk("clr_vs_set_out_ill", 32'(out_ill), 32'd1);
        @(posedge clk); #1;

        // Back-pressure: tags 1..6 with consumer stalled for four cycles
        begin
            int next_tag;
            int acc_n;
            int cyc;
            logic acc;
            logic take;
            logic [5:0] take_tag;
            next_tag  = 1;
            acc_n     = 0;
            out_ready = 1'b0;
            got_tags.delete();
            for (cyc = 0; cyc < 40 && got_tags.size() < 6; cyc++) begin
                if (cyc == 4) begin
                    chk("bp_accepted", 32'(acc_n), 32'd2);
                    chk("bp_in_ready", 32'(in_ready), 32'd0);
                    chk("bp_out_tag_held", 32'(out_tag), 32'd1);
                    chk("bp_out_valid", 32'(out_valid), 32'd1);
                    out_ready = 1'b1;
                end
                if (next_tag <= 6) drive(16'h0001, 1'b0, 4'd0, 1'b0, 6'(next_tag));
                else in_valid = 1'b0;
                @(negedge clk);
                acc      = in_valid && in_ready;
                take     = out_valid && out_ready;
                take_tag = out_tag;
                @(posedge clk); #1;
                if (acc) begin
                    next_tag++;
                    acc_n++;
                end
                if (take) got_tags.push_back(take_tag);
            end
            in_valid = 1'b0;
            chk("bp_count", 32'(got_tags.size()), 32'd6);
            for (int i = 0; i < got_tags.size(); i++)
                chk($sformatf("bp_order%0d", i), 32'(got_tags[i]), 32'(i + 1));
        end

        // Full throughput against a scoreboard
        begin
            int sent;
            int got;
            int stalls;
            int iters;
            logic acc;
            logic take;
            logic [15:0] rc;
            logic [3:0]  rcond;
            logic        rsig;
            logic        rsnan;
            @(posedge clk); #1;
            out_ready = 1'b1;
            sent = 0; got = 0; stalls = 0; iters = 0;
            sb.delete();
            while (iters < 60 && got < 32) begin
                if (sent < 32) begin
                    rc    = 16'($urandom);
                    rcond = 4'($urandom_range(0, 15));
                    rsig  = ($urandom_range(0, 3) == 0);
                    rsnan = ($urandom_range(0, 7) == 0);
                    drive(rc, rsnan, rcond, rsig, 6'(sent + 32));
                end else begin
                    in_valid = 1'b0;
                end
                @(negedge clk);
                acc  = in_valid && in_ready;
                take = out_valid && out_ready;
                if (in_valid && !in_ready) stalls++;
                if (acc) begin
                    m = model(in_cmp, in_snan, in_cond, in_sig);
                    sb.push_back({in_tag, m});
                    sent++;
                end
                if (take) begin
                    act_e = {out_tag, out_res, out_inv, out_ill};
                    if (sb.size() == 0) begin
                        chk("tp_unexpected_result", 32'(act_e), 32'h1FF);
                    end else begin
                        exp_e = sb.pop_front();
                        chk($sformatf("tp_result%0d", got), 32'(act_e), 32'(exp_e));
                    end
                    got++;
                end
                @(posedge clk); #1;
                iters++;
            end
            in_valid = 1'b0;
            chk("tp_count", 32'(got), 32'd32);
            chk("tp_stalls", 32'(stalls), 32'd0);
            chk("tp_cycles", 32'(iters), 32'd34);
        end

        // Asynchronous reset with two ops in flight
        begin
            int seen;
            @(posedge clk); #1;
            out_ready = 1'b0;
            drive(16'hFFFF, 1'b0, 4'd6, 1'b0, 6'd1);
            @(posedge clk); #1;
            drive(16'hFFFF, 1'b1, 4'd6, 1'b0, 6'd2);
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk("ar_pre_valid", 32'(out_valid), 32'd1);
            chk("ar_pre_flag_ill", 32'(flag_ill), 32'd1);
            #2 rst = 1'b1;
            #1;
            chk("ar_out_valid", 32'(out_valid), 32'd0);
            chk("ar_flags", 32'({flag_inv, flag_ill}), 32'd0);
            @(posedge clk); #1;
            rst = 1'b0;
            out_ready = 1'b1;
            seen = 0;
            repeat (5) begin
                @(negedge clk);
                if (out_valid) seen++;
            end
            chk("ar_no_stale", 32'(seen), 32'd0);
            chk("ar_flags_after", 32'({flag_inv, flag_ill}), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
